// File: rtl/pulse_train_sequencer.sv
// Burst pulse generator: emits `count` pulses of programmable high/low width,
// with start/busy/done handshake and abort.
module pulse_train_sequencer #(
   parameter int CW = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic [CW-1:0] count,
   input  logic [CW-1:0] high_len,
   input  logic [CW-1:0] low_len,
   output logic          signal,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] pulse_index
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

   localparam logic [CW-1:0] ONE = CW'(1);

   state_t        state;
   logic [CW-1:0] n_lat;
   logic [CW-1:0] h_lat;
   logic [CW-1:0] l_lat;
   logic [CW-1:0] phase;

   // Phase counter is loaded with cycles-remaining-minus-one; a zero length acts as one.
   function automatic logic [CW-1:0] len_m1(input logic [CW-1:0] len);
      return (len == '0) ? '0 : len - ONE;
   endfunction

   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= IDLE;
         signal      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pulse_index <= '0;
         n_lat       <= '0;
         h_lat       <= '0;
         l_lat       <= '0;
         phase       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start && !abort) begin
                  n_lat       <= count;
                  h_lat       <= high_len;
                  l_lat       <= low_len;
                  pulse_index <= '0;
                  if (count != '0) begin
                     state  <= HIGH;
                     signal <= 1'b1;
                     busy   <= 1'b1;
                     phase  <= len_m1(high_len);
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            HIGH: begin
               if (abort) begin
                  state       <= IDLE;
                  signal      <= 1'b0;
                  busy        <= 1'b0;
                  pulse_index <= '0;
                  phase       <= '0;
               end else if (phase == '0) begin
                  signal <= 1'b0;
                  // Last pulse ends the burst directly; no trailing gap.
                  if ((pulse_index + ONE) != n_lat) begin
                     state <= LOW;
                     phase <= len_m1(l_lat);
                  end else begin
                     state       <= DONE;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     pulse_index <= '0;
                  end
               end else begin
                  phase <= phase - ONE;
               end
            end
            LOW: begin
               if (abort) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  pulse_index <= '0;
                  phase       <= '0;
               end else if (phase == '0) begin
                  state       <= HIGH;
                  signal      <= 1'b1;
                  pulse_index <= pulse_index + ONE;
                  phase       <= len_m1(h_lat);
               end else begin
                  phase <= phase - ONE;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_train_sequencer.sv
// Directed plus randomized bench for pulse_train_sequencer, checked against
// a per-cycle expected-output list built from burst parameters.
module tb_pulse_train_sequencer;

   localparam int CW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [CW-1:0] count = '0;
   logic [CW-1:0] high_len = '0;
   logic [CW-1:0] low_len = '0;
   logic          signal;
   logic          busy;
   logic          done;
   logic [CW-1:0] pulse_index;

   int n_cmp = 0;
   int n_bad = 0;
   logic [CW+2:0] exp_q[$];

   pulse_train_sequencer #(.CW(CW)) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .count(count), .high_len(high_len), .low_len(low_len),
      .signal(signal), .busy(busy), .done(done), .pulse_index(pulse_index)
   );

   always #5 clock = ~clock;

   function automatic logic [CW+2:0] obs();
      return {signal, busy, done, pulse_index};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [CW+2:0] o, input logic [CW+2:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s {sig,busy,done,idx} observed=%h expected=%h", tag, o, e);
      end
   endtask

   // Expected output per cycle: N pulses of H high cycles, gaps of L between, then one done cycle.
   task automatic model(input int n, input int h, input int l);
      int hh;
      int ll;
      hh = (h == 0) ? 1 : h;
      ll = (l == 0) ? 1 : l;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         repeat (hh) exp_q.push_back({3'b110, CW'(i)});
         if (i < n - 1) repeat (ll) exp_q.push_back({3'b010, CW'(i)});
      end
      exp_q.push_back({3'b001, {CW{1'b0}}});
   endtask

   // kind: 0 = run to completion, 1 = abort after cycle `cut`, 2 = reset after cycle `cut`.
   task automatic burst(input int n, input int h, input int l, input bit hold,
                        input int kind, input int cut);
      count    = CW'(n);
      high_len = CW'(h);
      low_len  = CW'(l);
      start    = 1'b1;
      model(n, h, l);
      step();
      start = hold;
      for (int i = 0; i < exp_q.size(); i++) begin
         count    = CW'($urandom);
         high_len = CW'($urandom);
         low_len  = CW'($urandom);
         check($sformatf("burst n=%0d h=%0d l=%0d cyc=%0d", n, h, l, i), obs(), exp_q[i]);
         if (kind != 0 && i == cut) begin
            start = 1'b0;
            if (kind == 1) abort = 1'b1;
            else reset = 1'b0;
            step();
            check($sformatf("cancel kind=%0d cyc=%0d", kind, i), obs(), '0);
            abort = 1'b0;
            reset = 1'b1;
            step();
            check("quiet after cancel", obs(), '0);
            return;
         end
         step();
      end
      check($sformatf("idle after burst n=%0d", n), obs(), '0);
   endtask

   initial begin
      int n, h, l, kind, cut, sz;
      bit hold;

      // Reset held with start asserted.
      reset = 1'b0; start = 1'b1; count = 8'd4; high_len = 8'd3; low_len = 8'd3;
      step();
      check("reset cyc0", obs(), '0);
      step();
      check("reset cyc1", obs(), '0);
      reset = 1'b1;
      burst(4, 3, 3, 1'b0, 0, 0);

      burst(1, 0, 5, 1'b0, 0, 0);
      burst(0, 2, 2, 1'b0, 0, 0);

      // Start held: back-to-back bursts with fresh config each time.
      burst(4, 2, 2, 1'b1, 0, 0);
      burst(3, 1, 4, 1'b1, 0, 0);
      burst(2, 0, 0, 1'b0, 0, 0);

      // Abort in the LOW phase of pulse 1.
      burst(4, 2, 3, 1'b0, 1, 7);

      // Abort in IDLE beats start.
      start = 1'b1; abort = 1'b1; count = 8'd3; high_len = 8'd1; low_len = 8'd1;
      step();
      check("idle abort cyc0", obs(), '0);
      step();
      check("idle abort cyc1", obs(), '0);
      abort = 1'b0; start = 1'b0;
      step();
      check("idle abort release", obs(), '0);

      // Abort presented while DONE is showing: done already pulsed, then idle.
      burst(2, 1, 1, 1'b0, 1, 3);

      // Reset during HIGH of pulse 1, then a short burst.
      burst(4, 3, 3, 1'b0, 2, 6);
      burst(2, 1, 1, 1'b0, 0, 0);

      // Long phases and many pulses.
      burst(3, 255, 0, 1'b0, 0, 0);
      burst(255, 0, 0, 1'b0, 0, 0);

      for (int t = 0; t < 24; t++) begin
         n = $urandom_range(0, 6);
         h = $urandom_range(0, 4);
         l = $urandom_range(0, 4);
         hold = 1'($urandom_range(0, 1));
         kind = 0;
         cut = 0;
         if (n > 0 && $urandom_range(0, 3) == 0) begin
            kind = $urandom_range(1, 2);
            sz = n * ((h == 0) ? 1 : h) + (n - 1) * ((l == 0) ? 1 : l) + 1;
            cut = $urandom_range(0, sz - 2);
         end
         burst(n, h, l, hold, kind, cut);
      end
      start = 1'b0;
      step();
      step();
      check("final idle", obs(), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pulse_train_sequencer.md
Name: pulse_train_sequencer

Overview:
Clocked controller that sequences a programmable burst of pulses on a single output line. It turns the fixed 4-pulse pattern into a configured one: pulse count, high width and low width, all in clock cycles. A start/busy/done handshake and an abort input let a testbench or higher-level controller trigger and cancel bursts. It sits between the free-running clock generator and any block that consumes pulse trains.

Parameters:
CW, 8, width of the count, high_len, low_len and pulse_index fields

Ports:
clock  input  1  system clock; all logic on posedge clock
reset  input  1  synchronous, active-low reset
start  input  1  request a burst; sampled only in IDLE
abort  input  1  cancel the burst in progress
count  input  CW  number of pulses in the burst; latched at start accept
high_len  input  CW  high phase length in cycles; latched at start accept
low_len  input  CW  low gap length in cycles; latched at start accept
signal  output  1  pulse train output, registered
busy  output  1  high while a burst is in progress, registered
done  output  1  one-cycle completion strobe, registered
pulse_index  output  CW  zero-based index of the current pulse; 0 when not busy

Behaviour:
- Reset: synchronous, active-low. At a posedge with reset=0:
  - state goes to IDLE;
  - signal, busy, done and pulse_index go to 0;
  - all latched configuration and counters are cleared;
  - reset overrides every other input.
- States and transitions:
  - IDLE: start=1 and abort=0 with count!=0 -> HIGH. Config is latched. On the next cycle signal=1, busy=1, pulse_index=0.
  - IDLE with start=1, abort=0 and count=0 -> DONE. No pulse is emitted and busy stays 0.
  - HIGH: signal=1 for exactly H cycles. Then:
    - if pulse_index<N-1 -> LOW;
    - otherwise -> DONE.
  - LOW: signal=0 for exactly L cycles, then -> HIGH with pulse_index+1.
  - DONE: lasts exactly one cycle with done=1, busy=0, signal=0, then -> IDLE.
- Width rules:
  - latched high_len=0 is treated as 1, so H=max(high_len,1);
  - latched low_len=0 is treated as 1, so L=max(low_len,1);
  - N=count, with N in 1..2^CW-1;
  - phase counters are CW bits wide; no wrap-around is allowed inside a phase.
- Timing:
  - burst length = N*H + (N-1)*L busy cycles;
  - no trailing gap after the last pulse;
  - done rises on the cycle right after the last high cycle.
- Handshake:
  - start is ignored in HIGH, LOW and DONE;
  - configuration inputs may change freely while busy and have no effect until the next accepted start;
  - start held high continuously gives back-to-back bursts separated by the one DONE cycle plus one IDLE cycle.
- Abort:
  - abort=1 in HIGH or LOW -> IDLE on the next posedge, with signal=0, busy=0, pulse_index=0;
  - done is NOT asserted after an abort;
  - abort in IDLE wins over start, so no burst begins;
  - abort in DONE has no effect, and done still pulses.
- Outputs are all registered; there is no combinational path from any input to any output.

Test Plan:
- Reset held low for 2 cycles with start=1 -> signal, busy, done and pulse_index all 0 throughout. Release reset with count=4, high_len=3, low_len=3, start pulsed for 1 cycle -> signal pattern 111000111000111000111 (21 busy cycles), pulse_index steps 0,1,2,3, done=1 for exactly 1 cycle right after the 21st cycle.
- count=1, high_len=0, low_len=5 -> single 1-cycle high pulse, busy for 1 cycle, done on the next cycle.
- count=0, start pulsed -> signal and busy never rise; done=1 exactly one cycle after the start was sampled.
- count=4, high_len=2, low_len=2, start held high continuously, with the config inputs changed mid-burst -> second burst begins two cycles after done and uses the values latched at its own acceptance.
- Abort mid-burst: abort asserted during the 2nd pulse's LOW phase -> signal=0 and busy=0 next cycle, done never asserted, pulse_index=0.
- Reset mid-burst: reset=0 during HIGH of pulse 1 -> all outputs 0 at the next posedge. A later start=1 with count=2, high_len=1, low_len=1 -> pattern 101, then done.
